// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the multiplier pipeline:
// operand classes, flag bit positions and a canonical quiet-NaN builder.
package fp_pkg;

  typedef enum logic [2:0] {ZERO, NORMAL, INF, QNAN, SNAN} fp_class_t;

  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  localparam int NAN_MAX_W = 64;

  // Sign 0, exponent all ones, fraction MSB set; caller slices to its width.
  function automatic logic [NAN_MAX_W-1:0] canonNan(input int expW, input int manW);
    logic [NAN_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NAN_MAX_W; i++) begin
      if (i >= manW && i < manW + expW) r[i] = 1'b1;
    end
    r[manW-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final multiplier stage: round-to-nearest-even, carry into the exponent,
// overflow/underflow range check and packing; special results pass through.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     isSpecial,
  input  logic [EXP_W+MAN_W:0]     specialResult,
  input  logic [2:0]               specialFlags,
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  expIn,
  input  logic [MAN_W:0]           mant,
  input  logic                     guardBit,
  input  logic                     roundBit,
  input  logic                     stickyBit,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [2:0]               flags
);

  localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO = (EXP_W+2)'(0);

  logic                    roundUp;
  logic [MAN_W+1:0]        mantRnd;
  logic signed [EXP_W+1:0] expFin;

  assign roundUp = guardBit & (roundBit | stickyBit | mant[0]);
  assign mantRnd = {1'b0, mant} + {{(MAN_W+1){1'b0}}, roundUp};
  // On carry-out the fraction bits are all zero, so only the exponent moves.
  assign expFin  = expIn + {{(EXP_W+1){1'b0}}, mantRnd[MAN_W+1]};

  always_comb begin
    result = '0;
    flags  = '0;
    if (isSpecial) begin
      result = specialResult;
      flags  = specialFlags;
    end else if (expFin >= EXP_MAX) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLAG_OVERFLOW] = 1'b1;
    end else if (expFin <= EXP_ZERO) begin
      result = {sign, {(EXP_W+MAN_W){1'b0}}};
      flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      result = {sign, expFin[EXP_W-1:0], mantRnd[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier with a single global stall:
// classify/multiply, normalise/extract GRS, then round and pack.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [2:0]           out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W-1)) - 1;
  localparam int PW   = 2*MAN_W + 2;
  localparam logic [NAN_MAX_W-1:0]  NAN_FULL  = canonNan(EXP_W, MAN_W);
  localparam logic [W-1:0]          QNAN_WORD = NAN_FULL[W-1:0];
  localparam logic signed [EXP_W+1:0] BIAS_S  = (EXP_W+2)'(BIAS);

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)               return ZERO;
    else if (e != '1)          return NORMAL;
    else if (f == '0)          return INF;
    else if (f[MAN_W-1])       return QNAN;
    else                       return SNAN;
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---- S1: unpack, classify, exponent sum, mantissa product
  logic             signA, signB, signP;
  logic [EXP_W-1:0] expA, expB;
  logic [MAN_W-1:0] fracA, fracB;
  fp_class_t        clsA, clsB;
  logic             anyNan, infZero, isSpecialIn;
  logic [W-1:0]     specialIn;
  logic [2:0]       specialFlagsIn;
  logic signed [EXP_W+1:0] expSumIn;
  logic [PW-1:0]    prodIn;

  assign {signA, expA, fracA} = in_a;
  assign {signB, expB, fracB} = in_b;
  assign clsA    = classify(expA, fracA);
  assign clsB    = classify(expB, fracB);
  assign signP   = signA ^ signB;
  assign anyNan  = (clsA == QNAN) || (clsA == SNAN) || (clsB == QNAN) || (clsB == SNAN);
  assign infZero = ((clsA == INF) && (clsB == ZERO)) || ((clsA == ZERO) && (clsB == INF));

  always_comb begin
    isSpecialIn    = 1'b0;
    specialIn      = '0;
    specialFlagsIn = '0;
    if (anyNan || infZero) begin
      isSpecialIn = 1'b1;
      specialIn   = QNAN_WORD;
      specialFlagsIn[FLAG_INVALID] = infZero || (clsA == SNAN) || (clsB == SNAN);
    end else if ((clsA == INF) || (clsB == INF)) begin
      isSpecialIn = 1'b1;
      specialIn   = {signP, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if ((clsA == ZERO) || (clsB == ZERO)) begin
      isSpecialIn = 1'b1;
      specialIn   = {signP, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  assign expSumIn = $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS_S;
  assign prodIn   = {{(MAN_W+1){1'b0}}, 1'b1, fracA} * {{(MAN_W+1){1'b0}}, 1'b1, fracB};

  logic                    s1ValidReg, s1SpecialReg, s1SignReg;
  logic [W-1:0]            s1SpecialResReg;
  logic [2:0]              s1SpecialFlagsReg;
  logic signed [EXP_W+1:0] s1ExpReg;
  logic [PW-1:0]           s1ProdReg;

  // ---- S2: single-step normalise and guard/round/sticky extraction
  logic [MAN_W:0]          mantNext;
  logic                    guardNext, roundNext, stickyNext;
  logic signed [EXP_W+1:0] expNext;

  always_comb begin
    if (s1ProdReg[PW-1]) begin
      mantNext   = s1ProdReg[PW-1:MAN_W+1];
      guardNext  = s1ProdReg[MAN_W];
      roundNext  = s1ProdReg[MAN_W-1];
      stickyNext = |s1ProdReg[MAN_W-2:0];
      expNext    = s1ExpReg + (EXP_W+2)'(1);
    end else begin
      mantNext   = s1ProdReg[PW-2:MAN_W];
      guardNext  = s1ProdReg[MAN_W-1];
      roundNext  = s1ProdReg[MAN_W-2];
      stickyNext = |s1ProdReg[MAN_W-3:0];
      expNext    = s1ExpReg;
    end
  end

  logic                    s2ValidReg, s2SpecialReg, s2SignReg;
  logic [W-1:0]            s2SpecialResReg;
  logic [2:0]              s2SpecialFlagsReg;
  logic signed [EXP_W+1:0] s2ExpReg;
  logic [MAN_W:0]          s2MantReg;
  logic                    s2GuardReg, s2RoundReg, s2StickyReg;

  // ---- S3: round and pack
  logic [W-1:0] packResult;
  logic [2:0]   packFlags;

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) uRoundPack (
    .isSpecial     (s2SpecialReg),
    .specialResult (s2SpecialResReg),
    .specialFlags  (s2SpecialFlagsReg),
    .sign          (s2SignReg),
    .expIn         (s2ExpReg),
    .mant          (s2MantReg),
    .guardBit      (s2GuardReg),
    .roundBit      (s2RoundReg),
    .stickyBit     (s2StickyReg),
    .result        (packResult),
    .flags         (packFlags)
  );

  logic         outValidReg;
  logic [W-1:0] outResultReg;
  logic [2:0]   outFlagsReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1ValidReg <= 1'b0;  s1SpecialReg <= 1'b0;  s1SignReg <= 1'b0;
      s1SpecialResReg <= '0;  s1SpecialFlagsReg <= '0;  s1ExpReg <= '0;  s1ProdReg <= '0;
      s2ValidReg <= 1'b0;  s2SpecialReg <= 1'b0;  s2SignReg <= 1'b0;
      s2SpecialResReg <= '0;  s2SpecialFlagsReg <= '0;  s2ExpReg <= '0;  s2MantReg <= '0;
      s2GuardReg <= 1'b0;  s2RoundReg <= 1'b0;  s2StickyReg <= 1'b0;
      outValidReg <= 1'b0;  outResultReg <= '0;  outFlagsReg <= '0;
    end else if (advance) begin
      s1ValidReg        <= in_valid;
      s1SpecialReg      <= isSpecialIn;
      s1SignReg         <= signP;
      s1SpecialResReg   <= specialIn;
      s1SpecialFlagsReg <= specialFlagsIn;
      s1ExpReg          <= expSumIn;
      s1ProdReg         <= prodIn;
      s2ValidReg        <= s1ValidReg;
      s2SpecialReg      <= s1SpecialReg;
      s2SignReg         <= s1SignReg;
      s2SpecialResReg   <= s1SpecialResReg;
      s2SpecialFlagsReg <= s1SpecialFlagsReg;
      s2ExpReg          <= expNext;
      s2MantReg         <= mantNext;
      s2GuardReg        <= guardNext;
      s2RoundReg        <= roundNext;
      s2StickyReg       <= stickyNext;
      outValidReg       <= s2ValidReg;
      if (s2ValidReg) begin
        outResultReg <= packResult;
        outFlagsReg  <= packFlags;
      end
    end
  end

  assign out_valid  = outValidReg;
  assign out_result = outResultReg;
  assign out_flags  = outFlagsReg;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe in binary32: table of hand-computed
// products, then back-pressure and mid-flight reset sequences.
module tb_fp_mul_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  localparam int NVEC = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int checks = 0;
  int failures = 0;
  vec_t tbl [0:NVEC-1];

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  task automatic runOne(input int i);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = tbl[i].a;
    in_b      = tbl[i].b;
    #1;
    check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    check($sformatf("vec%0d_result", i), out_result, tbl[i].res);
    check($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(tbl[i].flg));
    $display("vec %0d: %08h x %08h -> %08h flags %03b (latency %0d)",
             i, tbl[i].a, tbl[i].b, out_result, out_flags, lat);
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int got;
    int extra;

    tbl[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000};
    tbl[1]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000};
    tbl[2]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b010};
    tbl[3]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b001};
    tbl[4]  = '{32'hFF800000, 32'h00000000, 32'h7FC00000, 3'b100};
    tbl[5]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b100};
    tbl[6]  = '{32'h40000000, 32'h40000000, 32'h40800000, 3'b000};
    tbl[7]  = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 3'b000};
    tbl[8]  = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 3'b000};
    tbl[9]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000};
    tbl[10] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000};
    tbl[11] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b000};
    tbl[12] = '{32'h80400000, 32'h3F800000, 32'h80000000, 3'b000};
    tbl[13] = '{32'h3F800000, 32'h00800000, 32'h00800000, 3'b000};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_out_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) runOne(i);

    // Back-to-back stream with consumer stalled for cycles 4..7.
    drain();
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 7);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_a = tbl[sent].a;
        in_b = tbl[sent].b;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 4 && cyc <= 7) begin
        check($sformatf("stall%0d_in_ready", cyc), 32'(in_ready), 32'd0);
        check($sformatf("stall%0d_out_valid", cyc), 32'(out_valid), 32'd1);
        check($sformatf("stall%0d_hold", cyc), out_result, tbl[got].res);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (got >= sent) begin
          check("stream_spurious", 32'(out_valid), 32'd0);
        end else begin
          check($sformatf("stream%0d_result", got), out_result, tbl[got].res);
          check($sformatf("stream%0d_flags", got), 32'(out_flags), 32'(tbl[got].flg));
          $display("stream %0d: cycle %0d -> %08h flags %03b", got, cyc, out_result, out_flags);
          got++;
        end
      end
    end
    check("stream_count", 32'(got), 32'd8);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid) extra++;
    end
    check("stream_no_dup", 32'(extra), 32'd0);

    // Reset asserted with two operand pairs in flight.
    drain();
    @(negedge clk);
    in_valid = 1'b1;
    in_a = tbl[0].a;
    in_b = tbl[0].b;
    @(negedge clk);
    in_a = tbl[6].a;
    in_b = tbl[6].b;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) extra++;
    end
    check("midreset_discarded", 32'(extra), 32'd0);
    $display("midreset: outputs seen after release = %0d", extra);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; the 32-bit binary32 format is EXP_W=8, MAN_W=23.
REQ-003 SHALL derive local W = 1+EXP_W+MAN_W and BIAS = 2^(EXP_W-1)-1.
REQ-004 SHALL have the following ports, in this order:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operand pair this cycle
- in_a  in  W  operand A, {sign, exponent, fraction}
- in_b  in  W  operand B, {sign, exponent, fraction}
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_result  out  W  product
- out_flags  out  3  {invalid, overflow, underflow}

Function
REQ-005 SHALL be a 3-stage pipeline:
- S1: unpack/classify, exponent sum, (MAN_W+1)x(MAN_W+1) product
- S2: 1-bit normalise, guard/round/sticky extraction
- S3: round, range check, pack
REQ-006 SHALL use a global advance = !out_valid || out_ready; in_ready = advance, combinational, with no dependence on in_valid.
REQ-007 SHALL accept a transfer when in_valid && in_ready; the result appears on out_valid exactly 3 cycles after acceptance when out_ready is held high.
REQ-008 SHALL freeze all stage registers, including valid bits, while advance=0; out_result/out_flags SHALL be stable while out_valid && !out_ready.
REQ-009 SHALL propagate bubbles without collapsing them; sustained throughput with out_ready=1 is one result per cycle.
REQ-010 SHALL treat an exponent field of 0 as zero (subnormal inputs flushed); sign is kept.
REQ-011 SHALL set the result sign to sign_a XOR sign_b for every non-NaN result.
REQ-012 SHALL apply these special-case priorities:
- any NaN operand, or Inf x 0 -> canonical quiet NaN (sign 0, exponent all-ones, fraction MSB 1, rest 0); invalid=1 only for signalling NaN or Inf x 0
- Inf x nonzero -> signed Inf, no flags
- 0 x finite -> signed zero, no flags
REQ-013 SHALL compute the unbiased-sum exponent as ea+eb-BIAS in EXP_W+2-bit signed arithmetic; no truncation before the range check.
REQ-014 SHALL normalise by one right shift, exponent +1, when product bit 2*MAN_W+1 is set.
REQ-015 SHALL round to nearest, ties to even, using guard, round and sticky (OR of all lower bits); a mantissa carry-out SHALL increment the exponent.
REQ-016 SHALL map a final exponent >= 2^EXP_W-1 to signed Inf with overflow=1.
REQ-017 SHALL map a final exponent <= 0 to signed zero with underflow=1; no subnormal outputs.
REQ-018 SHALL drive out_flags=0 whenever no flag condition holds.

Reset
REQ-019 SHALL, while rst_n=0, clear all stage valid bits; out_valid=0, out_result=0, out_flags=0.
REQ-020 SHALL, on reset assertion mid-operation, discard in-flight operands with no partial output.
REQ-021 SHALL have in_ready=1 from the first cycle after release.

Structure
REQ-022 SHALL import shared package fp_pkg containing:
- enum fp_class_t {ZERO, NORMAL, INF, QNAN, SNAN}
- flag bit-index constants
- canonical-NaN builder function parametrised by EXP_W/MAN_W
REQ-023 SHALL instantiate one sub-module, fp_round_pack (S3 logic: RNE, carry, range check, pack); classification stays inline.

Verification
REQ-024 SHALL cover: 3FC00000 x 40000000, out_ready=1 -> 40400000, flags 000, exactly 3 cycles after acceptance.
REQ-025 SHALL cover: 3F800001 x 3FC00000 (tie) -> 3FC00002, flags 000.
REQ-026 SHALL cover: 7F7FFFFF x 40000000 -> 7F800000, overflow=1; 00800000 x 3F000000 -> 00000000, underflow=1.
REQ-027 SHALL cover: FF800000 x 00000000 -> 7FC00000, invalid=1; 7F800001 x 3F800000 -> 7FC00000, invalid=1.
REQ-028 SHALL cover: 8 back-to-back pairs with out_ready low for cycles 4-7 -> in_ready low while stalled, no loss or duplication, results in order.
REQ-029 SHALL cover: rst_n pulsed low with 2 results in flight -> out_valid=0 next cycle, neither result ever emitted.
